// File: rtl/w_194_sequencer.sv
// Command sequencer driving a 74HC194-style 4-bit universal shift register.
// Define W_194_SEQ_ROTATE_EN to enable ROTATE_UP (CMD=11); otherwise it is ignored.
module w_194_sequencer #(
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             START,
    input  logic [1:0]       CMD,
    input  logic [CNT_W-1:0] COUNT,
    input  logic [0:3]       DATA,
    input  logic             FILL,
    input  logic [0:3]       Q,
    output logic [1:0]       S,
    output logic [1:0]       D,
    output logic [0:3]       IN,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_DOWN  = 2'b10;
    localparam logic [1:0] CMD_ROT   = 2'b11;
    localparam logic [1:0] S_HOLD    = 2'b00;
    localparam logic [1:0] S_UP      = 2'b01;
    localparam logic [1:0] S_DOWN    = 2'b10;
    localparam logic [1:0] S_LOAD    = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       s_q, s_d;
    logic [0:3]       in_q, in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fill_q, fill_d;
    logic             rot_q, rot_d;
    logic             cmd_ok;
    logic             accept;

`ifdef W_194_SEQ_ROTATE_EN
    assign cmd_ok = 1'b1;
`else
    assign cmd_ok = (CMD != CMD_ROT);
`endif

    // BUSY low covers both IDLE and FIN, which is what allows back-to-back starts
    assign accept = START && !busy_q && cmd_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        in_d    = in_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fill_d  = fill_q;
        rot_d   = rot_q;
        unique case (state_q)
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = FIN;
                    cnt_d   = CNT_ZERO;
                    s_d     = S_HOLD;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rot_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    fill_d = FILL;
                    rot_d  = (CMD == CMD_ROT);
                    if (CMD == CMD_LOAD) begin
                        state_d = RUN;
                        cnt_d   = CNT_ONE;
                        s_d     = S_LOAD;
                        in_d    = DATA;
                        busy_d  = 1'b1;
                    end else if (COUNT == CNT_ZERO) begin
                        state_d = FIN;
                        cnt_d   = CNT_ZERO;
                        s_d     = S_HOLD;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rot_d   = 1'b0;
                    end else begin
                        state_d = RUN;
                        cnt_d   = COUNT;
                        s_d     = (CMD == CMD_DOWN) ? S_DOWN : S_UP;
                        busy_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            s_q     <= S_HOLD;
            in_q    <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fill_q  <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fill_q  <= fill_d;
            rot_q   <= rot_d;
        end
    end

    assign S    = s_q;
    assign IN   = in_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef W_194_SEQ_ROTATE_EN
    // rotate feeds OUT[3] back into OUT[0] through the up-shift serial input
    assign D = {rot_q ? Q[3] : fill_q, fill_q};
`else
    assign D = {fill_q, fill_q};
    logic unused_fb;
    assign unused_fb = ^{Q, rot_q};
`endif

endmodule

// File: doc/w_194_sequencer.md
W_194_SEQUENCER -- requirements
Module: w_194_sequencer

Interface
REQ-001 SHALL have parameter: CNT_W, 3, width of the shift-count input and internal down-counter (max count 2^CNT_W-1).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port: CLK  in  1  clock, rising edge, shared with the controlled 74HC194-style register.
REQ-004 SHALL have port: MR  in  1  asynchronous active-high reset.
REQ-005 SHALL have port: START  in  1  command request, sampled at a rising edge while BUSY=0.
REQ-006 SHALL have port: CMD  in  2  00 LOAD, 01 SHIFT_UP, 10 SHIFT_DOWN, 11 ROTATE_UP.
REQ-007 SHALL have port: COUNT  in  CNT_W  number of shift steps, sampled with START.
REQ-008 SHALL have port: DATA  in  4  parallel load value, sampled with START.
REQ-009 SHALL have port: FILL  in  1  serial fill bit for shifts, sampled with START.
REQ-010 SHALL have port: Q  in  4  feedback from the register OUT[0:3].
REQ-011 SHALL have port: S  out  2  mode to register: 00 hold, 01 up (OUT[i+1]<=OUT[i], OUT[0]<=D[1]), 10 down (OUT[i]<=OUT[i+1], OUT[3]<=D[0]), 11 parallel load.
REQ-012 SHALL have port: D  out  2  serial inputs to register.
REQ-013 SHALL have port: IN  out  4  parallel data to register.
REQ-014 SHALL have port: BUSY  out  1  high while a command is executing.
REQ-015 SHALL have port: DONE  out  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, FIN; S, IN, BUSY, DONE, state and counter SHALL be registered.
REQ-017 SHALL accept START only when BUSY=0 (IDLE or FIN); START while BUSY=1 SHALL be ignored.
REQ-018 On an accepted START, the next edge SHALL enter RUN with BUSY=1, latch DATA into IN, latch FILL, load counter with COUNT (LOAD: 1), and drive S from CMD.
REQ-019 S SHALL be non-zero for exactly the counter-load number of consecutive cycles, each producing one register update.
REQ-020 The counter SHALL decrement every RUN cycle; on the edge where it equals 1, the block SHALL enter FIN with S=00, BUSY=0, DONE=1.
REQ-021 FIN SHALL last one cycle, then return to IDLE (DONE=0), unless START is accepted in FIN, which SHALL enter RUN directly (back-to-back, no idle cycle).
REQ-022 COUNT=0 with a shift or rotate CMD SHALL skip RUN: next edge enters FIN with DONE=1 and S=00.
REQ-023 D[0] SHALL equal the latched fill; D[1] SHALL equal the latched fill, except during ROTATE_UP where D[1] SHALL equal Q[3] combinationally.
REQ-024 IN SHALL hold its value until the next accepted LOAD.

Reset
REQ-025 MR=1 SHALL immediately force state IDLE, counter 0, S=00, D=00, IN=0000, BUSY=0, DONE=0, fill=0, including mid-command; no DONE SHALL be produced for the aborted command.
REQ-026 The first START SHALL be accepted at the first rising edge after MR deasserts.

Configuration
REQ-027 With macro W_194_SEQ_ROTATE_EN defined, CMD=11 SHALL execute ROTATE_UP per REQ-023.
REQ-028 Without W_194_SEQ_ROTATE_EN, START with CMD=11 SHALL be ignored (no BUSY, no DONE, S stays 00), and D[1] SHALL always equal the latched fill.

Verification
REQ-029 SHALL verify: LOAD DATA=1010 -> S=11 for 1 cycle, Q=1010, DONE pulse on the following cycle.
REQ-030 SHALL verify: Q=1010, SHIFT_UP COUNT=2 FILL=1 -> S=01 for 2 cycles, then Q=1110 (Q[0:3] order), DONE once.
REQ-031 SHALL verify: Q=0001, ROTATE_UP COUNT=4 (macro on) -> Q=0001 after 4 cycles; macro off -> no BUSY, Q unchanged.
REQ-032 SHALL verify: SHIFT_DOWN COUNT=0 -> S stays 00, DONE exactly one cycle after START, BUSY never high.
REQ-033 SHALL verify: MR pulse during SHIFT_UP COUNT=7 at cycle 3 -> S=00, BUSY=0, no DONE, Q cleared by the register.
REQ-034 SHALL verify: START asserted during BUSY is ignored, START in the FIN cycle starts the next command with no gap.
